// File: rtl/vga_fb_pkg.sv
// Shared timing defaults, word widths and prefetch FSM encoding for the
// framebuffer scanout arbiter.
package vga_fb_pkg;

    localparam int unsigned H_DISPLAY_DEF = 800;
    localparam int unsigned H_TOTAL_DEF   = 1034;
    localparam int unsigned V_DISPLAY_DEF = 600;
    localparam int unsigned V_TOTAL_DEF   = 662;
    localparam int unsigned PIX_W_DEF     = 8;
    localparam int unsigned ADDR_W_DEF    = 19;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain
    } fetch_state_e;

endpackage

// File: rtl/vga_fb_scanout_arbiter_line_buffer.sv
// Ping-pong line buffer: two banks of one display line, bank chosen by the address MSB.
// The read port is registered and returns zero when the read enable is low.
module fb_line_buffer #(
    parameter int unsigned Words = 800,
    parameter int unsigned Width = 8,
    localparam int unsigned XW   = $clog2(Words)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             we_i,
    input  logic [XW:0]      waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             re_i,
    input  logic [XW:0]      raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [2][Words];
    logic [Width-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i[XW]][waddr_i[XW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i[XW]][raddr_i[XW-1:0]];
        end else begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_fb_scanout_arbiter.sv
// Shares one single-port framebuffer RAM between line prefetch (absolute priority)
// and a host write port; streams the current line from a ping-pong line buffer.
module vga_fb_scanout_arbiter
    import vga_fb_pkg::*;
#(
    parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
    parameter int unsigned H_TOTAL   = H_TOTAL_DEF,
    parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
    parameter int unsigned V_TOTAL   = V_TOTAL_DEF,
    parameter int unsigned PIX_W     = PIX_W_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [10:0]       hpos_i,
    input  logic [9:0]        vpos_i,
    input  logic              display_on_i,
    output logic [PIX_W-1:0]  pix_o,
    output logic              pix_valid_o,
    input  logic              host_valid_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [PIX_W-1:0]  host_data_i,
    output logic              host_ready_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [PIX_W-1:0]  mem_wdata_o,
    input  logic [PIX_W-1:0]  mem_rdata_i,
    output logic              underrun_o
);

    localparam int unsigned XW    = $clog2(H_DISPLAY);
    localparam logic [XW-1:0] XLast = XW'(H_DISPLAY - 1);
    localparam logic [10:0]   HSwap = 11'(H_TOTAL - 1);
    localparam logic [9:0]    VLast = 10'(V_TOTAL - 1);
    localparam logic [9:0]    VVis  = 10'(V_DISPLAY);

    fetch_state_e      state_q, state_d;
    logic              disp_bank_q, disp_bank_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [XW-1:0]     fetch_x_q, fetch_x_d;
    logic              underrun_q, underrun_d;
    logic              rd_pend_q, rd_bank_q, disp_on_q;
    logic [XW-1:0]     rd_x_q;

    logic [9:0] next_line;
    logic       line_vis, trigger, swap, host_ready;

    assign next_line  = (vpos_i == VLast) ? '0 : vpos_i + 10'd1;
    assign line_vis   = next_line < VVis;
    assign trigger    = (hpos_i == '0) && line_vis;
    assign swap       = (hpos_i == HSwap) && line_vis;
    // Gated by reset so the host sees not-ready while the block is held in reset.
    assign host_ready = rstn_i && (state_q == StIdle) && !trigger;

    always_comb begin
        state_d      = state_q;
        disp_bank_d  = disp_bank_q;
        fetch_addr_d = fetch_addr_q;
        fetch_x_d    = fetch_x_q;
        underrun_d   = 1'b0;
        mem_en_o     = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = fetch_addr_q;
        unique case (state_q)
            StIdle: begin
                if (trigger) begin
                    state_d   = StFetch;
                    fetch_x_d = '0;
                    if (next_line == '0) begin
                        fetch_addr_d = '0;
                    end
                end else if (host_valid_i && host_ready) begin
                    mem_en_o   = 1'b1;
                    mem_we_o   = 1'b1;
                    mem_addr_o = host_addr_i;
                end
            end
            StFetch: begin
                mem_en_o     = 1'b1;
                fetch_addr_d = fetch_addr_q + ADDR_W'(1);
                fetch_x_d    = fetch_x_q + XW'(1);
                if (fetch_x_q == XLast) begin
                    state_d = StDrain;
                end
            end
            StDrain: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // The swap is never delayed; an unfinished prefetch is abandoned and flagged.
        if (swap) begin
            disp_bank_d = ~disp_bank_q;
            if (state_q != StIdle) begin
                underrun_d = 1'b1;
                state_d    = StIdle;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= StIdle;
            disp_bank_q  <= 1'b0;
            fetch_addr_q <= '0;
            fetch_x_q    <= '0;
            underrun_q   <= 1'b0;
            rd_pend_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            rd_x_q       <= '0;
            disp_on_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            disp_bank_q  <= disp_bank_d;
            fetch_addr_q <= fetch_addr_d;
            fetch_x_q    <= fetch_x_d;
            underrun_q   <= underrun_d;
            // Target bank is latched with the read so a late word never lands in the shown bank.
            rd_pend_q    <= (state_q == StFetch);
            rd_bank_q    <= ~disp_bank_q;
            rd_x_q       <= fetch_x_q;
            disp_on_q    <= display_on_i;
        end
    end

    fb_line_buffer #(
        .Words (H_DISPLAY),
        .Width (PIX_W)
    ) u_line_buffer (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .we_i    (rd_pend_q),
        .waddr_i ({rd_bank_q, rd_x_q}),
        .wdata_i (mem_rdata_i),
        .re_i    (display_on_i),
        .raddr_i ({disp_bank_q, hpos_i[XW-1:0]}),
        .rdata_o (pix_o)
    );

    assign host_ready_o = host_ready;
    assign mem_wdata_o  = host_data_i;
    assign pix_valid_o  = disp_on_q;
    assign underrun_o   = underrun_q;

endmodule

// File: tb/tb_vga_fb_scanout_arbiter.sv
// Randomized bench for vga_fb_scanout_arbiter against a frame-level reference model.
module tb_vga_fb_scanout_arbiter;

    localparam int HD = 8, HT = 12, VD = 4, VT = 6, PW = 8, AW = 6, HT2 = 10;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    // Main instance signals
    logic [10:0] hpos;  logic [9:0] vpos;  logic don;
    logic hv;  logic [AW-1:0] ha;  logic [PW-1:0] hd;
    logic hr, men, mwe, pixv, und;
    logic [AW-1:0] maddr;  logic [PW-1:0] mwd, mrd, pix;

    // Short-line instance signals
    logic [10:0] hpos2;  logic [9:0] vpos2;  logic don2;
    logic hr2, men2, mwe2, pixv2, und2;
    logic [AW-1:0] maddr2;  logic [PW-1:0] mwd2, mrd2, pix2;

    vga_fb_scanout_arbiter #(
        .H_DISPLAY(HD), .H_TOTAL(HT), .V_DISPLAY(VD), .V_TOTAL(VT), .PIX_W(PW), .ADDR_W(AW)
    ) u_dut (
        .clk_i(clk), .rstn_i(rstn), .hpos_i(hpos), .vpos_i(vpos), .display_on_i(don),
        .pix_o(pix), .pix_valid_o(pixv), .host_valid_i(hv), .host_addr_i(ha),
        .host_data_i(hd), .host_ready_o(hr), .mem_en_o(men), .mem_we_o(mwe),
        .mem_addr_o(maddr), .mem_wdata_o(mwd), .mem_rdata_i(mrd), .underrun_o(und)
    );

    vga_fb_scanout_arbiter #(
        .H_DISPLAY(HD), .H_TOTAL(HT2), .V_DISPLAY(VD), .V_TOTAL(VT), .PIX_W(PW), .ADDR_W(AW)
    ) u_dut_short (
        .clk_i(clk), .rstn_i(rstn), .hpos_i(hpos2), .vpos_i(vpos2), .display_on_i(don2),
        .pix_o(pix2), .pix_valid_o(pixv2), .host_valid_i(1'b0), .host_addr_i('0),
        .host_data_i('0), .host_ready_o(hr2), .mem_en_o(men2), .mem_we_o(mwe2),
        .mem_addr_o(maddr2), .mem_wdata_o(mwd2), .mem_rdata_i(mrd2), .underrun_o(und2)
    );

    // Physical RAMs seen by the DUTs
    logic preload;
    logic [PW-1:0] ram [64];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) ram[i] <= PW'(i);
        end else if (men) begin
            if (mwe) ram[maddr] <= mwd;
            else     mrd <= ram[maddr];
        end
    end
    always @(posedge clk) begin
        if (men2 && !mwe2) mrd2 <= PW'(maddr2);
    end

    // Reference model state
    int n_vec = 0, n_err = 0;
    int h_cnt, v_cnt, frame = 0, h2, v2;
    int prev_h = 0, prev_v = 0, prev2_h = -1, prev2_v = 0;
    bit prev_don = 0, prev2_don = 0;
    bit host_acc = 0, host_rand = 0, do_aa = 1, aa_armed = 0;
    int aa_frame = 0;
    logic [PW-1:0] mdl_ram [64];
    logic [PW-1:0] pend_line [HD];
    logic [PW-1:0] exp_line [HD];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int next_line(input int v);
        return (v == VT - 1) ? 0 : v + 1;
    endfunction

    task automatic drive();
        hpos = 11'(h_cnt);
        vpos = 10'(v_cnt);
        don  = (h_cnt < HD) && (v_cnt < VD);
    endtask

    task automatic drive2();
        hpos2 = 11'(h2);
        vpos2 = 10'(v2);
        don2  = (h2 < HD) && (v2 < VD);
    endtask

    task automatic adv();
        if (host_acc) hv = 1'b0;
        host_acc = 1'b0;
        h_cnt++;
        if (h_cnt == HT) begin
            h_cnt = 0;
            v_cnt++;
            if (v_cnt == VT) begin
                v_cnt = 0;
                frame++;
            end
        end
        drive();
        if (do_aa && v_cnt == 0 && h_cnt == 0) begin
            hv = 1'b1; ha = AW'(9); hd = 8'hAA; do_aa = 0;
        end else if (host_rand && !hv && $urandom_range(0, 2) == 0) begin
            hv = 1'b1;
            ha = AW'($urandom_range(0, 63));
            if (ha == AW'(9)) ha = AW'(41);
            hd = PW'($urandom);
        end
    endtask

    // Expected behaviour of one cycle of the main instance, from the line-level rules.
    task automatic model_cycle();
        int nl, addr;
        bit vis, busy, en, we;
        logic [PW-1:0] ep;
        nl   = next_line(v_cnt);
        vis  = nl < VD;
        busy = vis && (h_cnt <= HD + 1);
        en = 0; we = 0; addr = 0;
        if (busy && h_cnt >= 1 && h_cnt <= HD) begin
            en = 1; addr = nl * HD + h_cnt - 1;
        end else if (!busy && hv) begin
            en = 1; we = 1; addr = int'(ha);
        end
        check_eq("host_ready", 32'(hr), 32'(!busy));
        check_eq("mem_en", 32'(men), 32'(en));
        check_eq("mem_we", 32'(mwe), 32'(we));
        if (en) check_eq("mem_addr", 32'(maddr), 32'(addr));
        if (we) check_eq("mem_wdata", 32'(mwd), 32'(hd));
        ep = prev_don ? exp_line[prev_h] : '0;
        check_eq("pix_valid", 32'(pixv), 32'(prev_don));
        check_eq("pix", 32'(pix), 32'(ep));
        check_eq("underrun", 32'(und), 32'(0));
        if (aa_armed && frame > aa_frame && prev_v == 1 && prev_h == 1 && prev_don)
            check_eq("host_write_pixel", 32'(pix), 32'hAA);
        if (h_cnt == 0 && vis)
            for (int x = 0; x < HD; x++) pend_line[x] = mdl_ram[nl * HD + x];
        if (!busy && hv) begin
            mdl_ram[ha] = hd;
            host_acc = 1;
            if (ha == AW'(9) && hd == 8'hAA) begin
                aa_armed = 1; aa_frame = frame; host_rand = 1;
            end
        end
        if (h_cnt == HT - 1 && vis) exp_line = pend_line;
        prev_h = h_cnt; prev_v = v_cnt;
        prev_don = (h_cnt < HD) && (v_cnt < VD);
    endtask

    // Short-line instance: prefetch cannot finish before the swap point.
    task automatic model_short();
        int nl;
        bit vis, busy, en, eu;
        nl   = next_line(v2);
        vis  = nl < VD;
        busy = vis && (h2 <= HD + 1);
        en   = busy && h2 >= 1 && h2 <= HD;
        check_eq("short_host_ready", 32'(hr2), 32'(!busy));
        check_eq("short_mem_en", 32'(men2), 32'(en));
        check_eq("short_mem_we", 32'(mwe2), 32'(0));
        check_eq("short_mem_wdata", 32'(mwd2), 32'(0));
        if (en) check_eq("short_mem_addr", 32'(maddr2), 32'(nl * HD + h2 - 1));
        eu = (prev2_h == HT2 - 1) && (next_line(prev2_v) < VD) && (prev2_h <= HD + 1);
        check_eq("short_underrun", 32'(und2), 32'(eu));
        check_eq("short_pix_valid", 32'(pixv2), 32'(prev2_don));
        check_eq("short_pix", 32'(pix2), prev2_don ? 32'(PW'(prev2_v * HD + prev2_h)) : 32'(0));
        prev2_h = h2; prev2_v = v2;
        prev2_don = (h2 < HD) && (v2 < VD);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) model_cycle();
            @(posedge clk);
            #1 adv();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_host_ready"}, 32'(hr), 32'(0));
        check_eq({tag, "_mem_en"}, 32'(men), 32'(0));
        check_eq({tag, "_mem_we"}, 32'(mwe), 32'(0));
        check_eq({tag, "_pix_valid"}, 32'(pixv), 32'(0));
        check_eq({tag, "_pix"}, 32'(pix), 32'(0));
        check_eq({tag, "_underrun"}, 32'(und), 32'(0));
    endtask

    initial begin
        rstn = 1'b0;
        preload = 1'b1;
        for (int i = 0; i < 64; i++) mdl_ram[i] = PW'(i);
        for (int x = 0; x < HD; x++) begin
            pend_line[x] = '0; exp_line[x] = '0;
        end
        h_cnt = 0; v_cnt = 4; drive();
        hv = 1'b0; ha = '0; hd = '0;
        h2 = 1; v2 = 4; drive2();
        #1 check_reset_outputs("reset");
        @(posedge clk); #1 preload = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;

        // Normal frames: directed write to address 9, then random host traffic
        run(HT * VT * 4);

        // Asynchronous reset in the middle of a prefetch and of a displayed line
        for (int i = 0; i < 200 && !(v_cnt == 0 && h_cnt == 4); i++) run(1);
        #1 begin
            rstn = 1'b0;
            hv = 1'b1;
        end
        #1 check_reset_outputs("midfetch_reset");
        repeat (2) begin
            @(negedge clk) check_reset_outputs("held_reset");
        end
        @(posedge clk);
        #1 begin
            h_cnt = 0; v_cnt = 4; drive();
            hv = 1'b0; host_acc = 0; prev_don = 0;
            rstn = 1'b1;
        end
        run(HT * VT * 2);

        // Short lines: the swap arrives before the prefetch drains
        h_cnt = 1; v_cnt = 4; drive(); hv = 1'b0;
        h2 = 0; v2 = 5; drive2();
        prev2_h = -1; prev2_don = 0;
        for (int i = 0; i < HT2 * 5; i++) begin
            @(negedge clk) model_short();
            @(posedge clk);
            #1 begin
                h2++;
                if (h2 == HT2) begin
                    h2 = 0;
                    v2 = (v2 == VT - 1) ? 0 : v2 + 1;
                end
                drive2();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_fb_scanout_arbiter.md
Name: vga_fb_scanout_arbiter

Overview:
Shares one single-port framebuffer RAM between display scanout and a host writer. It runs from the hpos/vpos/display_on outputs of the HVSync timing generator. Each line it prefetches the next display line into a ping-pong line buffer and streams the current line out as pixels. The host write port gets every memory cycle the prefetch does not use.

Parameters:
H_DISPLAY, 800, visible pixels per line
H_TOTAL, 1034, clocks per line (800+53+120+61); must be >= H_DISPLAY+3
V_DISPLAY, 600, visible lines
V_TOTAL, 662, lines per frame (600+21+35+6)
PIX_W, 8, bits per pixel / RAM word
ADDR_W, 19, framebuffer word address width; must satisfy 2^ADDR_W >= H_DISPLAY*V_DISPLAY

Ports:
clk_i  in  1  pixel clock
rstn_i  in  1  reset, asynchronous, active-low
hpos_i  in  11  horizontal position from HVSync
vpos_i  in  10  vertical position from HVSync
display_on_i  in  1  visible-area flag from HVSync
pix_o  out  PIX_W  pixel for the display pipeline
pix_valid_o  out  1  pix_o is in the visible area
host_valid_i  in  1  host write request
host_addr_i  in  ADDR_W  host write address
host_data_i  in  PIX_W  host write data
host_ready_o  out  1  host write accepted when valid&ready
mem_en_o  out  1  RAM access strobe
mem_we_o  out  1  RAM write enable
mem_addr_o  out  ADDR_W  RAM address
mem_wdata_o  out  PIX_W  RAM write data
mem_rdata_i  in  PIX_W  RAM read data, valid 1 cycle after a read strobe
underrun_o  out  1  one-cycle pulse when a prefetch is incomplete at the line swap

Behaviour:
- Reset, asynchronous on rstn_i low, all registers cleared:
  - state=IDLE, disp_bank=0, fetch_addr=0, fetch_x=0.
  - pix_o=0, pix_valid_o=0, underrun_o=0.
  - mem_en_o=0, mem_we_o=0.
  - host_ready_o=0 while rstn_i is low; it follows the IDLE rule after release.
- next_line = (vpos_i==V_TOTAL-1) ? 0 : vpos_i+1.
- Trigger: hpos_i==0 and next_line<V_DISPLAY.
  - Sets state<=FETCH, fetch_x<=0.
  - If next_line==0, also sets fetch_addr<=0; otherwise fetch_addr continues from where the previous line ended.
  - The trigger cycle itself is still IDLE.
- Fetch FSM: IDLE -> FETCH -> DRAIN -> IDLE.
  - FETCH, each cycle: mem_en_o=1, mem_we_o=0, mem_addr_o=fetch_addr. Then fetch_addr++ and fetch_x++.
  - After the read with fetch_x==H_DISPLAY-1, go to DRAIN.
  - Read data returns one cycle after its strobe and is written to linebuf[~disp_bank][x_delayed]. DRAIN captures the last word, then returns to IDLE.
  - Fetch completes H_DISPLAY+2 cycles after the trigger.
- Host port:
  - host_ready_o = (state==IDLE) && !trigger. It does not depend on host_valid_i.
  - On valid&ready in the same cycle: mem_en_o=1, mem_we_o=1, mem_addr_o=host_addr_i, mem_wdata_o=host_data_i.
  - Prefetch has absolute priority; host is never granted during FETCH or DRAIN.
  - The host may hold valid; data and address must stay stable until accepted.
- Idle memory: mem_en_o=0 and mem_we_o=0 when neither requester uses the RAM.
- Bank swap, at hpos_i==H_TOTAL-1 when next_line<V_DISPLAY: disp_bank<=~disp_bank.
  - If state!=IDLE at that point: underrun_o pulses for 1 cycle and the FSM is forced to IDLE. The swap still happens.
- Scanout:
  - Cycle t: linebuf[disp_bank][hpos_i] is read.
  - Cycle t+1: pix_o shows that value and pix_valid_o = display_on_i delayed by 1.
  - pix_o=0 when the delayed display_on is 0.
  - Latency from hpos to pixel is 1 clock.
- mem outputs are combinational from state/handshake; all other outputs are registered.

Decomposition:
- Package vga_fb_pkg holds:
  - the timing constants shared with HVSync (H_DISPLAY, H_TOTAL, V_DISPLAY, V_TOTAL);
  - the FSM state encoding (IDLE, FETCH, DRAIN);
  - the PIX_W/ADDR_W defaults.
- Sub-module fb_line_buffer: 2*H_DISPLAY x PIX_W, one write port and one registered read port, bank selected by the address MSB.

Test Plan:
All tests use H_DISPLAY=8, H_TOTAL=12, V_DISPLAY=4, V_TOTAL=6 unless noted.
1. Reset release with host idle -> host_ready_o=1, mem_en_o=0, pix_valid_o=0; assert rstn_i mid-FETCH -> everything returns to reset values immediately.
2. vpos=5, hpos=0 -> next 8 cycles read addresses 0..7 with mem_we_o=0. RAM preloaded with value = address. On line 0, pix_o=0..7 one clock after hpos 0..7.
3. Line 1 prefetch at vpos=0 -> reads addresses 8..15; frame wrap at vpos=5 -> address restarts at 0.
4. host_valid_i held high through a fetch -> host_ready_o=0 from the trigger cycle through DRAIN. Write accepted at hpos=10 with mem_we_o=1. Earlier host write at the trigger cycle (hpos=0) is refused.
5. Host writes 0xAA to address 9 during line 0 -> on the next frame, line 1 pixel 1 = 0xAA.
6. H_TOTAL=10 (violates the H_DISPLAY+3 limit) -> underrun_o pulses at hpos=9, FSM back to IDLE, bank still swaps.
